// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer
//   Power-up and recovery sequencer for the NES/VGA clocking resource.
//   Holds the PLL in reset, waits for PLL and BUFPLL lock, confirms that lock
//   is stable, then releases the VGA/TMDS domain reset followed by the NES core
//   reset. Lock loss or a reinit request restarts the whole sequence.
//
// Ports
//   i_clk            free-running board clock (runs ahead of the PLL)
//   i_rst            synchronous active-high reset
//   i_pll_locked     PLL LOCKED, asynchronous to i_clk
//   i_bufpll_locked  BUFPLL LOCK, asynchronous to i_clk
//   i_reinit_req     single-cycle pulse, restart the sequence
//   o_pll_rst        PLL reset drive, active-high
//   o_vga_rst        video/serializer domain reset, active-high
//   o_nes_rst        NES core reset, active-high
//   o_ready          high only in RUN
//   o_state          current state encoding
//   o_fault_cnt      saturating count of lock timeouts and lock losses
//
// state       | code | meaning
// S_PLL_RST   | 0    | PLL held in reset for PLL_RST_CYCLES
// S_WAIT_LOCK | 1    | waiting for both locks, retry after LOCK_TIMEOUT_CYCLES
// S_STABLE    | 2    | locks must stay high LOCK_STABLE_CYCLES in a row
// S_REL_VGA   | 3    | VGA domain released, NES still in reset
// S_RUN       | 4    | everything released
module clk_rst_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int VGA_TO_NES_CYCLES   = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_locked,
  input  logic       i_bufpll_locked,
  input  logic       i_reinit_req,
  output logic       o_pll_rst,
  output logic       o_vga_rst,
  output logic       o_nes_rst,
  output logic       o_ready,
  output logic [2:0] o_state,
  output logic [7:0] o_fault_cnt
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_B   = (LOCK_TIMEOUT_CYCLES > VGA_TO_NES_CYCLES) ? LOCK_TIMEOUT_CYCLES : VGA_TO_NES_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  // Counter only ever needs to reach CNT_MAX-1.
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] V2N_LAST     = CNT_W'(VGA_TO_NES_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_REL_VGA   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_pll_sync;
  logic [1:0]       r_buf_sync;
  logic             w_lock_ok;
  logic             w_fault_inc;
  logic [7:0]       r_fault_cnt;
  logic             r_pll_rst;
  logic             r_vga_rst;
  logic             r_nes_rst;
  logic             r_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pll_sync <= 2'b00;
      r_buf_sync <= 2'b00;
    end else begin
      r_pll_sync <= {r_pll_sync[0], i_pll_locked};
      r_buf_sync <= {r_buf_sync[0], i_bufpll_locked};
    end
  end

  assign w_lock_ok = r_pll_sync[1] & r_buf_sync[1];

  always_comb begin
    w_state_nxt = r_state;
    w_fault_inc = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == PLL_RST_LAST) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_lock_ok) begin
          w_state_nxt = S_STABLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_state_nxt = S_PLL_RST;
          w_fault_inc = 1'b1;
        end
      end
      S_STABLE: begin
        // A glitch here is not a fault; just go back and requalify.
        if (!w_lock_ok)                 w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == STABLE_LAST)  w_state_nxt = S_REL_VGA;
      end
      S_REL_VGA: begin
        if (!w_lock_ok) begin
          w_state_nxt = S_PLL_RST;
          w_fault_inc = 1'b1;
        end else if (r_cnt == V2N_LAST) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_lock_ok) begin
          w_state_nxt = S_PLL_RST;
          w_fault_inc = 1'b1;
        end
      end
      default: w_state_nxt = S_PLL_RST;
    endcase
    // Reinit overrides any fault; ignored while already in PLL_RST so the
    // reset pulse is never stretched.
    if (i_reinit_req && (r_state != S_PLL_RST)) begin
      w_state_nxt = S_PLL_RST;
      w_fault_inc = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_PLL_RST;
      r_cnt       <= '0;
      r_fault_cnt <= 8'd0;
      r_pll_rst   <= 1'b1;
      r_vga_rst   <= 1'b1;
      r_nes_rst   <= 1'b1;
      r_ready     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else                        r_cnt <= r_cnt + CNT_W'(1);
      if (w_fault_inc && (r_fault_cnt != 8'hFF)) r_fault_cnt <= r_fault_cnt + 8'd1;
      // Outputs decoded from the next state so they move on the same edge
      // as the state register.
      r_pll_rst <= (w_state_nxt == S_PLL_RST);
      r_vga_rst <= !((w_state_nxt == S_REL_VGA) || (w_state_nxt == S_RUN));
      r_nes_rst <= (w_state_nxt != S_RUN);
      r_ready   <= (w_state_nxt == S_RUN);
    end
  end

  assign o_pll_rst   = r_pll_rst;
  assign o_vga_rst   = r_vga_rst;
  assign o_nes_rst   = r_nes_rst;
  assign o_ready     = r_ready;
  assign o_state     = r_state;
  assign o_fault_cnt = r_fault_cnt;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
module tb_clk_rst_sequencer;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       bufpll_locked;
  logic       reinit_req;
  logic       pll_rst;
  logic       vga_rst;
  logic       nes_rst;
  logic       ready;
  logic [2:0] state;
  logic [7:0] fault_cnt;

  int checks = 0;
  int errors = 0;

  clk_rst_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .VGA_TO_NES_CYCLES  (3)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_pll_locked   (pll_locked),
    .i_bufpll_locked(bufpll_locked),
    .i_reinit_req   (reinit_req),
    .o_pll_rst      (pll_rst),
    .o_vga_rst      (vga_rst),
    .o_nes_rst      (nes_rst),
    .o_ready        (ready),
    .o_state        (state),
    .o_fault_cnt    (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, pll_rst, vga_rst, nes_rst, ready, fault_cnt}
  logic [14:0] obs;
  assign obs = {state, pll_rst, vga_rst, nes_rst, ready, fault_cnt};

  localparam logic [14:0] RESET_VEC = {3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};

  // Expected outputs n edges after a clean start of the sequence with locks
  // already good: PLL_RST edges 0..3, WAIT_LOCK at 4, STABLE 5..12,
  // RELEASE_VGA 13..15, RUN from 16.
  function automatic logic [14:0] exp_vec(int n, logic [7:0] f);
    logic [2:0] s;
    if (n < 4)       s = 3'd0;
    else if (n < 5)  s = 3'd1;
    else if (n < 13) s = 3'd2;
    else if (n < 16) s = 3'd3;
    else             s = 3'd4;
    return {s, 1'(n < 4), 1'(n < 13), 1'(n < 16), 1'(n >= 16), f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(logic lk);
    rst = 1'b1;
    pll_locked = lk;
    bufpll_locked = lk;
    reinit_req = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_values got %h exp %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_release();
    logic [14:0] e;
    apply_reset(1'b1);
    for (int n = 1; n <= 16; n++) begin
      tick();
      e = exp_vec(n, 8'd0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL release edge %0d got %h exp %h", n, obs, e);
      end
    end
  endtask

  task automatic test_stable_glitch();
    logic [2:0] es;
    apply_reset(1'b1);
    for (int n = 1; n <= 19; n++) begin
      tick();
      if (n == 7) pll_locked = 1'b0;
      if (n == 8) pll_locked = 1'b1;
      if (n < 4)       es = 3'd0;
      else if (n == 4) es = 3'd1;
      else if (n < 10) es = 3'd2;
      else if (n == 10) es = 3'd1;
      else if (n < 19) es = 3'd2;
      else             es = 3'd3;
      checks++;
      if ({state, vga_rst, fault_cnt} !== {es, 1'(n < 19), 8'd0}) begin
        errors++;
        $display("FAIL stable_glitch edge %0d got state %0d vga %0b fault %0d exp state %0d vga %0b fault 0",
                 n, state, vga_rst, fault_cnt, es, (n < 19));
      end
    end
  endtask

  task automatic test_timeout();
    logic [14:0] e;
    int f;
    int ph;
    apply_reset(1'b0);
    for (int n = 1; n <= 255 * 36 + 108; n++) begin
      tick();
      ph = n % 36;
      f = n / 36;
      if (f > 255) f = 255;
      e = {(ph < 4) ? 3'd0 : 3'd1, 1'(ph < 4), 1'b1, 1'b1, 1'b0, 8'(f)};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL timeout edge %0d got %h exp %h", n, obs, e);
      end
    end
  endtask

  task automatic test_run_lock_loss();
    logic [14:0] e;
    apply_reset(1'b1);
    for (int n = 1; n <= 16; n++) tick();
    bufpll_locked = 1'b0;
    tick();
    tick();
    checks++;
    if ({state, ready} !== {3'd4, 1'b1}) begin
      errors++;
      $display("FAIL loss_latency got state %0d ready %0b exp state 4 ready 1", state, ready);
    end
    tick();
    bufpll_locked = 1'b1;
    e = {3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL run_lock_loss got %h exp %h", obs, e);
    end
    for (int n = 1; n <= 16; n++) begin
      tick();
      e = exp_vec(n, 8'd1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rerun edge %0d got %h exp %h", n, obs, e);
      end
    end
  endtask

  // Continues from RUN left by test_run_lock_loss (fault_cnt = 1).
  task automatic test_rst_mid();
    bufpll_locked = 1'b0;
    tick();
    tick();
    tick();
    bufpll_locked = 1'b1;
    for (int n = 1; n <= 14; n++) tick();
    checks++;
    if ({state, vga_rst, nes_rst, fault_cnt} !== {3'd3, 1'b0, 1'b1, 8'd2}) begin
      errors++;
      $display("FAIL pre_rst got state %0d vga %0b nes %0b fault %0d exp state 3 vga 0 nes 1 fault 2",
               state, vga_rst, nes_rst, fault_cnt);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL rst_mid got %h exp %h", obs, RESET_VEC);
    end
    rst = 1'b0;
  endtask

  task automatic test_reinit_lockloss();
    logic [14:0] e;
    apply_reset(1'b1);
    for (int n = 1; n <= 16; n++) tick();
    bufpll_locked = 1'b0;
    tick();
    tick();
    reinit_req = 1'b1;
    tick();
    reinit_req = 1'b0;
    bufpll_locked = 1'b1;
    e = {3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reinit_wins got %h exp %h", obs, e);
    end
    tick();
    reinit_req = 1'b1;
    tick();
    reinit_req = 1'b0;
    tick();
    checks++;
    if ({state, pll_rst} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reinit_in_pll_rst r3 got state %0d pll_rst %0b exp state 0 pll_rst 1", state, pll_rst);
    end
    tick();
    checks++;
    if ({state, pll_rst, fault_cnt} !== {3'd1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reinit_no_extend got state %0d pll_rst %0b fault %0d exp state 1 pll_rst 0 fault 0",
               state, pll_rst, fault_cnt);
    end
    for (int n = 5; n <= 16; n++) tick();
    checks++;
    if (obs !== exp_vec(16, 8'd0)) begin
      errors++;
      $display("FAIL reinit_rerun got %h exp %h", obs, exp_vec(16, 8'd0));
    end
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b1;
    bufpll_locked = 1'b1;
    reinit_req = 1'b0;
    test_reset();
    test_release();
    test_stable_glitch();
    test_run_lock_loss();
    test_rst_mid();
    test_reinit_lockloss();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
